// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin trigger/echo-timing controller for NUM_CH ultrasonic rangefinders.
// Each enabled channel is fired in turn; its echo width is converted to whole cm and held.
module ultrasonic_scan_ctrl #(
    parameter int NUM_CH     = 6,
    parameter int DIST_W     = 9,
    parameter int CYC_PER_US = 50,
    parameter int US_PER_CM  = 58,
    parameter int TRIG_US    = 10,
    parameter int ECHO_TO_US = 30000,
    parameter int GAP_US     = 10000
) (
    input  logic                                         clk_clk,
    input  logic                                         reset_reset_n,
    input  logic                                         enable,
    input  logic [NUM_CH-1:0]                            chan_mask,
    input  logic [NUM_CH-1:0]                            echo,
    output logic [NUM_CH-1:0]                            trig,
    output logic [NUM_CH*DIST_W-1:0]                     dist_cm,
    output logic [NUM_CH-1:0]                            dist_valid,
    output logic [NUM_CH-1:0]                            timeout_flag,
    output logic                                         sample_stb,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sample_ch,
    output logic                                         busy
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CM_CYC   = CYC_PER_US * US_PER_CM;
    localparam int TRIG_CYC = TRIG_US * CYC_PER_US;
    localparam int TO_CYC   = ECHO_TO_US * CYC_PER_US;
    localparam int GAP_CYC  = GAP_US * CYC_PER_US;
    localparam int TMR_MAX  = (TO_CYC > GAP_CYC) ? ((TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC)
                                                 : ((GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC);
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int PRE_W    = (CM_CYC > 1) ? $clog2(CM_CYC) : 1;

    localparam logic [TMR_W-1:0]  TRIG_LAST = TMR_W'(TRIG_CYC - 1);
    localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(TO_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP_CYC - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CM_CYC - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = {DIST_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t                         r_state, w_state_nxt;
    logic [CH_W-1:0]                r_ch, w_next_ch, w_low_ch, w_above_ch;
    logic                           w_any_mask, w_has_above;
    logic [NUM_CH-1:0]              r_echo_s1, r_echo_s2, r_echo_d;
    logic                           w_echo, w_rise;
    logic [TMR_W-1:0]               r_tmr;
    logic [PRE_W-1:0]               r_pre, w_pre_base, w_pre_nxt;
    logic [DIST_W-1:0]              r_cm, w_cm_base, w_cm_nxt;
    logic [NUM_CH-1:0][DIST_W-1:0]  r_dist;
    logic [NUM_CH-1:0]              r_trig, r_valid, r_to;
    logic                           r_stb;
    logic [CH_W-1:0]                r_sample_ch;
    logic                           w_select, w_trig_off, w_tmr_clr;
    logic                           w_meas_start, w_meas_step, w_write, w_wr_to;

    // Next channel: lowest mask bit above the current one, else the lowest overall.
    always_comb begin
        w_any_mask  = 1'b0;
        w_has_above = 1'b0;
        w_low_ch    = '0;
        w_above_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                w_any_mask = 1'b1;
                w_low_ch   = CH_W'(i);
                if (CH_W'(i) > r_ch) begin
                    w_has_above = 1'b1;
                    w_above_ch  = CH_W'(i);
                end
            end
        end
        w_next_ch = w_has_above ? w_above_ch : w_low_ch;
    end

    assign w_echo = r_echo_s2[r_ch];
    assign w_rise = r_echo_s2[r_ch] & ~r_echo_d[r_ch];

    // The rising-edge cycle is itself the first high cycle, so it is counted here.
    always_comb begin
        w_pre_base = w_meas_start ? '0 : r_pre;
        w_cm_base  = w_meas_start ? '0 : r_cm;
        if (w_pre_base == PRE_LAST) begin
            w_pre_nxt = '0;
            w_cm_nxt  = (w_cm_base == DIST_MAX) ? w_cm_base : w_cm_base + 1'b1;
        end else begin
            w_pre_nxt = w_pre_base + 1'b1;
            w_cm_nxt  = w_cm_base;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_state_nxt  = r_state;
        w_select     = 1'b0;
        w_trig_off   = 1'b0;
        w_tmr_clr    = 1'b0;
        w_meas_start = 1'b0;
        w_meas_step  = 1'b0;
        w_write      = 1'b0;
        w_wr_to      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_any_mask) begin
                    w_select    = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_TRIG;
                end
            end
            S_TRIG: begin
                if (r_tmr == TRIG_LAST) begin
                    w_trig_off  = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (w_rise) begin
                    w_meas_start = 1'b1;
                    w_state_nxt  = S_MEASURE;
                end else if (r_tmr == TO_LAST) begin
                    w_write     = 1'b1;
                    w_wr_to     = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_MEASURE: begin
                if (!w_echo) begin
                    w_write     = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (r_tmr >= TO_LAST) begin
                    w_write     = 1'b1;
                    w_wr_to     = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_GAP;
                end else begin
                    w_meas_step = 1'b1;
                end
            end
            S_GAP: begin
                if (r_tmr == GAP_LAST) begin
                    w_tmr_clr = 1'b1;
                    if (enable && w_any_mask) begin
                        w_select    = 1'b1;
                        w_state_nxt = S_TRIG;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_echo_s1   <= '0;
            r_echo_s2   <= '0;
            r_echo_d    <= '0;
            r_ch        <= CH_W'(NUM_CH - 1);
            r_tmr       <= '0;
            r_pre       <= '0;
            r_cm        <= '0;
            // NOTE: the result bank is reset too; software sees cleared distances after any reset.
            r_dist      <= '0;
            r_trig      <= '0;
            r_valid     <= '0;
            r_to        <= '0;
            r_stb       <= 1'b0;
            r_sample_ch <= '0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
            r_stb     <= w_write;

            if (w_tmr_clr || r_state == S_IDLE) begin
                r_tmr <= '0;
            end else if (w_meas_start) begin
                r_tmr <= TMR_W'(1);
            end else begin
                r_tmr <= r_tmr + 1'b1;
            end

            if (w_meas_start || w_meas_step) begin
                r_pre <= w_pre_nxt;
                r_cm  <= w_cm_nxt;
            end

            if (w_select) begin
                r_ch   <= w_next_ch;
                r_trig <= NUM_CH'(1) << w_next_ch;
            end else if (w_trig_off) begin
                r_trig <= '0;
            end

            if (w_write) begin
                r_dist[r_ch] <= w_wr_to ? DIST_MAX : r_cm;
                r_to[r_ch]   <= w_wr_to;
                r_valid[r_ch] <= 1'b1;
                r_sample_ch  <= r_ch;
            end
        end
    end

    assign trig         = r_trig;
    assign dist_cm      = r_dist;
    assign dist_valid   = r_valid;
    assign timeout_flag = r_to;
    assign sample_stb   = r_stb;
    assign sample_ch    = r_sample_ch;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Directed bench for ultrasonic_scan_ctrl: 3-channel instance plus a 1-channel DIST_W=4 instance
// for saturation. Timing: CM_CYC=2, trigger 3, timeout 100, gap 5 cycles.
module tb_ultrasonic_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  mask = '0;
    logic [2:0]  echo = '0;
    logic [2:0]  trig;
    logic [26:0] dist_cm;
    logic [2:0]  dist_valid;
    logic [2:0]  timeout_flag;
    logic        sample_stb;
    logic [1:0]  sample_ch;
    logic        busy;

    logic        enable4 = 1'b0;
    logic        mask4 = 1'b0;
    logic        echo4 = 1'b0;
    logic        trig4;
    logic [3:0]  dist4;
    logic        valid4;
    logic        to4;
    logic        stb4;
    logic        sch4;
    logic        busy4;

    int n_assert = 0;
    int n_fail = 0;
    int k;
    int n;
    logic [2:0] exp_order [4] = '{3'b100, 3'b001, 3'b100, 3'b001};

    always #5 clk = ~clk;

    ultrasonic_scan_ctrl #(
        .NUM_CH(3), .DIST_W(9), .CYC_PER_US(1), .US_PER_CM(2),
        .TRIG_US(3), .ECHO_TO_US(100), .GAP_US(5)
    ) u_dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .chan_mask(mask),
        .echo(echo), .trig(trig), .dist_cm(dist_cm), .dist_valid(dist_valid),
        .timeout_flag(timeout_flag), .sample_stb(sample_stb), .sample_ch(sample_ch),
        .busy(busy)
    );

    ultrasonic_scan_ctrl #(
        .NUM_CH(1), .DIST_W(4), .CYC_PER_US(1), .US_PER_CM(2),
        .TRIG_US(3), .ECHO_TO_US(100), .GAP_US(5)
    ) u_dut4 (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable4), .chan_mask(mask4),
        .echo(echo4), .trig(trig4), .dist_cm(dist4), .dist_valid(valid4),
        .timeout_flag(to4), .sample_stb(stb4), .sample_ch(sch4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles = 1);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_trig(input int ch, input string tag);
        int c = 0;
        while (trig[ch] !== 1'b1 && c < 500) begin tick(); c++; end
        check(tag, 32'(trig[ch]), 32'd1);
    endtask

    task automatic count_high(input int ch, output int cnt);
        cnt = 0;
        while (trig[ch] === 1'b1 && cnt < 500) begin tick(); cnt++; end
    endtask

    task automatic wait_stb(input string tag, output int cnt);
        cnt = 0;
        while (sample_stb !== 1'b1 && cnt < 500) begin tick(); cnt++; end
        check(tag, 32'(sample_stb), 32'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick(3);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_dist", 32'(dist_cm), 32'd0);
        check("rst_valid", 32'(dist_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stb", 32'(sample_stb), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Mask all-zero keeps the scanner idle while the saturation instance runs.
        enable  = 1'b1;
        mask    = 3'b000;
        enable4 = 1'b1;
        mask4   = 1'b1;
        k = 0;
        while (trig4 !== 1'b1 && k < 500) begin tick(); k++; end
        check("d4_trig", 32'(trig4), 32'd1);
        k = 0;
        while (trig4 === 1'b1 && k < 500) begin tick(); k++; end
        echo4 = 1'b1;
        tick(40);
        echo4 = 1'b0;
        k = 0;
        while (stb4 !== 1'b1 && k < 500) begin tick(); k++; end
        check("d4_stb", 32'(stb4), 32'd1);
        check("d4_sat", 32'(dist4), 32'd15);
        check("d4_to", 32'(to4), 32'd0);
        enable4 = 1'b0;
        check("mask0_busy", 32'(busy), 32'd0);
        check("mask0_trig", 32'(trig), 32'd0);

        // Basic 20-cycle echo on ch0.
        mask = 3'b111;
        wait_trig(0, "basic_trig0");
        count_high(0, n);
        check("trig0_width", 32'(n), 32'd3);
        echo[0] = 1'b1;
        tick(20);
        echo[0] = 1'b0;
        wait_stb("basic_stb", k);
        check("basic_ch", 32'(sample_ch), 32'd0);
        check("basic_dist", 32'(dist_cm[8:0]), 32'd10);
        check("basic_to", 32'(timeout_flag), 32'd0);
        check("basic_valid", 32'(dist_valid), 32'b001);
        tick();
        check("stb_one_cycle", 32'(sample_stb), 32'd0);
        k = 1;
        while (trig[1] !== 1'b1 && k < 500) begin tick(); k++; end
        check("gap_len", 32'(k), 32'd5);

        // No echo on ch1: timeout 100 cycles after the trigger ends.
        count_high(1, n);
        check("trig1_width", 32'(n), 32'd3);
        wait_stb("to1_stb", k);
        check("to1_wait", 32'(k), 32'd100);
        check("to1_ch", 32'(sample_ch), 32'd1);
        check("to1_dist", 32'(dist_cm[17:9]), 32'd511);
        check("to1_flag", 32'(timeout_flag), 32'b010);
        check("to1_valid", 32'(dist_valid), 32'b011);

        // Echo held high 150 cycles on ch2: 2 sync cycles + 100 high cycles.
        wait_trig(2, "long_trig2");
        count_high(2, n);
        echo[2] = 1'b1;
        wait_stb("long_stb", k);
        check("long_wait", 32'(k), 32'd102);
        check("long_dist", 32'(dist_cm[26:18]), 32'd511);
        check("long_flag", 32'(timeout_flag), 32'b110);
        check("long_valid", 32'(dist_valid), 32'b111);
        tick(48);
        echo[2] = 1'b0;

        // ch0 is now waiting for a rise: 21-cycle echo floors to 10.
        echo[0] = 1'b1;
        tick(21);
        echo[0] = 1'b0;
        wait_stb("r21_stb", k);
        check("r21_ch", 32'(sample_ch), 32'd0);
        check("r21_dist", 32'(dist_cm[8:0]), 32'd10);

        // 8-cycle echo on ch1 clears its timeout flag.
        wait_trig(1, "e8_trig1");
        count_high(1, n);
        echo[1] = 1'b1;
        tick(8);
        echo[1] = 1'b0;
        wait_stb("e8_stb", k);
        check("e8_dist", 32'(dist_cm[17:9]), 32'd4);
        check("e8_flag", 32'(timeout_flag), 32'b100);

        // Mask 101 from ch1: order 2,0,2,0.
        mask = 3'b101;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (trig === 3'b000 && k < 500) begin tick(); k++; end
            check("order", 32'(trig), 32'(exp_order[i]));
            k = 0;
            while (trig !== 3'b000 && k < 500) begin tick(); k++; end
        end

        // Enable dropped mid-MEASURE on ch2: result still written, then IDLE.
        wait_trig(2, "drop_trig2");
        count_high(2, n);
        echo[2] = 1'b1;
        tick(4);
        enable = 1'b0;
        tick(6);
        echo[2] = 1'b0;
        wait_stb("drop_stb", k);
        check("drop_ch", 32'(sample_ch), 32'd2);
        check("drop_dist", 32'(dist_cm[26:18]), 32'd5);
        check("drop_flag", 32'(timeout_flag), 32'b001);
        tick(10);
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_idle_trig", 32'(trig), 32'd0);

        // Echo already high at trigger is ignored until a fresh rise.
        mask = 3'b001;
        echo[0] = 1'b1;
        tick(5);
        enable = 1'b1;
        wait_trig(0, "pre_trig0");
        count_high(0, n);
        tick(3);
        echo[0] = 1'b0;
        tick(6);
        echo[0] = 1'b1;
        tick(10);
        echo[0] = 1'b0;
        wait_stb("pre_stb", k);
        check("pre_dist", 32'(dist_cm[8:0]), 32'd5);
        check("pre_flag", 32'(timeout_flag), 32'b000);

        // Async reset in the middle of a measurement.
        wait_trig(0, "rstm_trig0");
        count_high(0, n);
        echo[0] = 1'b1;
        tick(5);
        mask = 3'b110;
        #2 rst_n = 1'b0;
        #1;
        check("rstm_trig", 32'(trig), 32'd0);
        check("rstm_dist", 32'(dist_cm), 32'd0);
        check("rstm_valid", 32'(dist_valid), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        echo[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        k = 0;
        while (trig === 3'b000 && k < 500) begin tick(); k++; end
        check("restart_ch1", 32'(trig), 32'b010);
        enable = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
